command_executor: RTL and testbench
===================================

# command_executor

Downstream consumer of the command decoder: captures each decoded request on its `done` pulse and executes it against a word-addressed 32-bit memory port. It then reports the outcome to the host through the UART transmitter byte interface. A write produces a one-byte status reply; a read produces a status byte followed by four data bytes.

## Interface
Parameters:
- MEM_DEPTH, 1024: number of valid 32-bit words. Addresses ≥ MEM_DEPTH are out of range.
- READ_LATENCY, 1: clock cycles from o_mem_addr valid to i_mem_rdata valid. Legal values are 1 or 2.

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low
- i_command  input  8  decoded command byte (information only; i_readwrite selects the operation)
- i_address  input  15  decoded word address
- i_data  input  32  decoded write data, byte 0 = bits 7:0
- i_readwrite  input  1  1 = read, 0 = write
- i_error  input  2  decoder error code; 0 = none
- i_done  input  1  one-cycle request strobe; other i_* inputs are valid in the same cycle
- o_mem_addr  output  15  memory word address
- o_mem_wdata  output  32  memory write data
- o_mem_we  output  1  one-cycle write strobe
- i_mem_rdata  input  32  memory read data
- o_tx_byte  output  8  byte to transmit
- o_tx_start  output  1  one-cycle transmit request
- i_tx_busy  input  1  transmitter busy
- o_busy  output  1  high from request capture until the last reply byte is accepted
- o_dropped  output  1  one-cycle pulse when i_done arrives while o_busy is high

## Operation
- **Reset (reset = 0 at an edge):**
  - All outputs go to 0, the state goes to IDLE, and the captured registers clear.
  - This applies at any point, including mid-reply. No further o_tx_start is issued after reset.
- **Status byte:** {4'hA, range_err, rw, err[1:0]}.
  - range_err = (i_address ≥ MEM_DEPTH) and err = 0.
  - rw = i_readwrite and err = 0 and range_err = 0.
  - Resulting values: write OK = 0xA0; read OK = 0xA4; decoder errors = 0xA1, 0xA2, 0xA3; out of range = 0xA8 for a write or 0xA8 for a read.
- **States:**
  - IDLE: o_busy = 0. On i_done, capture address, data, rw and err, compute the status, set o_busy = 1 and go to DECIDE.
  - DECIDE: if err ≠ 0 or range_err = 1, go to SEND_STATUS with no memory access. If rw = 0, go to WRITE. Otherwise go to READ.
  - WRITE: o_mem_addr = address, o_mem_wdata = data, o_mem_we = 1 for exactly this cycle. Then go to SEND_STATUS.
  - READ: o_mem_addr = address. Wait READ_LATENCY cycles in READ_WAIT, latch i_mem_rdata into the reply shift register, then go to SEND_STATUS.
  - SEND_STATUS: wait until i_tx_busy = 0, then pulse o_tx_start with o_tx_byte = status. Go to TX_HOLD with bytes_left = 4 for an OK read, otherwise 0.
  - TX_HOLD: one cycle in which i_tx_busy is ignored, covering the transmitter's busy-assert delay. Then go to TX_WAIT.
  - TX_WAIT:
    - Wait for i_tx_busy = 0.
    - If bytes_left = 0, go to IDLE; o_busy drops on entry to IDLE.
    - Otherwise pulse o_tx_start with o_tx_byte = shift[7:0], shift right by 8, decrement bytes_left, and go to TX_HOLD.
- Read data is sent least-significant byte first, matching the decoder's data byte order.
- An i_done arriving in any state other than IDLE is ignored, and o_dropped pulses on the following cycle.
- o_mem_we never asserts for error or out-of-range requests.
- Unreachable state encodings return to IDLE with all strobes at 0.

## Timing
- Call the cycle in which i_done is high cycle 0.
  - DECIDE is cycle 1.
  - For a write, o_mem_we is high in cycle 2 and the earliest o_tx_start is cycle 3.
  - For a read with READ_LATENCY = 1, o_mem_addr is valid from cycle 2, data is latched at the end of cycle 3, and the earliest o_tx_start is cycle 4.
- o_tx_start and o_tx_byte change together. o_tx_byte holds its value until the next o_tx_start.
- o_tx_start is never high in two consecutive cycles, and is never issued while i_tx_busy = 1, except in the TX_HOLD cycle, where i_tx_busy is deliberately ignored.
- If i_tx_busy is held high, the block stalls indefinitely without losing data.

## Test plan
- **Write OK:** i_done with rw = 0, addr = 0x0012, data = 0xDEADBEEF, err = 0 → o_mem_we for one cycle in cycle 2 with addr 0x0012 and wdata 0xDEADBEEF; single o_tx_start with byte 0xA0; o_busy low afterwards.
- **Read OK:** memory model returns 0x11223344 at addr 0x0005 → tx bytes 0xA4, 0x44, 0x33, 0x22, 0x11 in order; no o_mem_we. Repeat with READ_LATENCY = 2.
- **Errors:** i_error = 2'b10 with rw = 1 → single byte 0xA2, no memory access. addr = 0x0400 with MEM_DEPTH = 1024 → single byte 0xA8.
- **Busy/backpressure:** hold i_tx_busy high for 50 cycles after each start → no overlapping starts and bytes unchanged. Issue a second i_done mid-reply → o_dropped pulses once and the reply is unaffected.
- **Reset mid-read-reply:** assert reset after the second data byte → all outputs 0 on the next edge, and no further o_tx_start until a new i_done.

Source files
------------

// File: rtl/command_executor.sv
// Executes decoded read/write requests against a word-addressed memory port and
// reports a status byte (plus four data bytes for a successful read) to the UART.
module command_executor #(
    parameter int MEM_DEPTH    = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  i_command,
    input  logic [14:0] i_address,
    input  logic [31:0] i_data,
    input  logic        i_readwrite,
    input  logic [1:0]  i_error,
    input  logic        i_done,
    output logic [14:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_we,
    input  logic [31:0] i_mem_rdata,
    output logic [7:0]  o_tx_byte,
    output logic        o_tx_start,
    input  logic        i_tx_busy,
    output logic        o_busy,
    output logic        o_dropped
);
    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        DECIDE      = 4'd1,
        WRITE       = 4'd2,
        READ        = 4'd3,
        READ_WAIT   = 4'd4,
        SEND_STATUS = 4'd5,
        TX_HOLD     = 4'd6,
        TX_WAIT     = 4'd7
    } state_t;

    localparam logic [31:0] DEPTH     = 32'(MEM_DEPTH);
    localparam logic [1:0]  WAIT_INIT = 2'(READ_LATENCY - 1);

    state_t      state_r;
    logic [14:0] address_r;
    logic [31:0] data_r;
    logic        rw_r;
    logic [7:0]  status_r;
    logic [31:0] shift_r;
    logic [2:0]  bytes_left_r;
    logic [1:0]  wait_cnt_r;
    logic        request_bad_s;
    logic [2:0]  reply_len_s;
    logic        unused_s;

    // Status layout {A, range_err, rw, err}; the rw bit is set only for a clean read.
    function automatic logic [7:0] make_status(input logic [14:0] addr, input logic rw,
                                               input logic [1:0] err);
        logic range_err;
        logic rw_ok;
        range_err = ({17'd0, addr} >= DEPTH) && (err == 2'd0);
        rw_ok     = rw && (err == 2'd0) && !range_err;
        return {4'hA, range_err, rw_ok, err};
    endfunction

    assign request_bad_s = status_r[3] || (status_r[1:0] != 2'd0);
    assign reply_len_s   = status_r[2] ? 3'd4 : 3'd0;
    assign unused_s      = ^i_command;

    // Request sequencing, memory strobes and the byte-at-a-time transmit handshake.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= IDLE;
            address_r    <= 15'd0;
            data_r       <= 32'd0;
            rw_r         <= 1'b0;
            status_r     <= 8'd0;
            shift_r      <= 32'd0;
            bytes_left_r <= 3'd0;
            wait_cnt_r   <= 2'd0;
            o_mem_addr   <= 15'd0;
            o_mem_wdata  <= 32'd0;
            o_mem_we     <= 1'b0;
            o_tx_byte    <= 8'd0;
            o_tx_start   <= 1'b0;
            o_busy       <= 1'b0;
            o_dropped    <= 1'b0;
        end else begin
            o_mem_we   <= 1'b0;
            o_tx_start <= 1'b0;
            o_dropped  <= i_done && o_busy;
            case (state_r)
                IDLE: begin
                    if (i_done) begin
                        address_r <= i_address;
                        data_r    <= i_data;
                        rw_r      <= i_readwrite;
                        status_r  <= make_status(i_address, i_readwrite, i_error);
                        o_busy    <= 1'b1;
                        state_r   <= DECIDE;
                    end else begin
                        o_busy <= 1'b0;
                    end
                end
                DECIDE: begin
                    if (request_bad_s) begin
                        state_r <= SEND_STATUS;
                    end else if (!rw_r) begin
                        o_mem_addr  <= address_r;
                        o_mem_wdata <= data_r;
                        o_mem_we    <= 1'b1;
                        state_r     <= WRITE;
                    end else begin
                        o_mem_addr <= address_r;
                        state_r    <= READ;
                    end
                end
                READ: begin
                    wait_cnt_r <= WAIT_INIT;
                    state_r    <= READ_WAIT;
                end
                READ_WAIT: begin
                    if (wait_cnt_r != 2'd0) begin
                        wait_cnt_r <= wait_cnt_r - 2'd1;
                    end else begin
                        shift_r <= i_mem_rdata;
                        // Issue the status straight away when the transmitter is free.
                        if (!i_tx_busy) begin
                            o_tx_start   <= 1'b1;
                            o_tx_byte    <= status_r;
                            bytes_left_r <= reply_len_s;
                            state_r      <= TX_HOLD;
                        end else begin
                            state_r <= SEND_STATUS;
                        end
                    end
                end
                WRITE, SEND_STATUS: begin
                    if (!i_tx_busy) begin
                        o_tx_start   <= 1'b1;
                        o_tx_byte    <= status_r;
                        bytes_left_r <= reply_len_s;
                        state_r      <= TX_HOLD;
                    end else begin
                        state_r <= SEND_STATUS;
                    end
                end
                TX_HOLD: begin
                    state_r <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (i_tx_busy) begin
                        state_r <= TX_WAIT;
                    end else if (bytes_left_r == 3'd0) begin
                        o_busy  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        o_tx_start   <= 1'b1;
                        o_tx_byte    <= shift_r[7:0];
                        shift_r      <= {8'd0, shift_r[31:8]};
                        bytes_left_r <= bytes_left_r - 3'd1;
                        state_r      <= TX_HOLD;
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_command_executor.sv
// Self-checking bench: two executors (read latency 1 and 2) share the request stream;
// each has its own memory pipeline and transmitter model, checked against a reference.
module tb_command_executor;
    logic        clock   = 1'b0;
    logic        reset   = 1'b0;
    logic [7:0]  cmd_in  = 8'd0;
    logic [14:0] addr_in = 15'd0;
    logic [31:0] data_in = 32'd0;
    logic        rw_in   = 1'b0;
    logic [1:0]  err_in  = 2'd0;
    logic        done_in = 1'b0;

    logic [14:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [7:0]  tx_byte   [2];
    logic [31:0] pipe1     [2];
    logic [31:0] pipe2     [2];
    logic [1:0]  mem_we, tx_start, tx_busy, busy, dropped;

    logic [31:0] mem [1024];
    int          tx_hold = 2;
    int          tx_cnt [2] = '{0, 0};
    int          cyc = 0;
    int          done_cyc = 0;
    logic [7:0]  tx_log [2][64];
    int          tx_rel [2][64];
    int          tx_n   [2] = '{0, 0};
    int          we_n   [2] = '{0, 0};
    logic [14:0] we_addr_log [2];
    logic [31:0] we_data_log [2];
    int          we_rel_log  [2];
    int          drop_n [2] = '{0, 0};
    int          viol   [2] = '{0, 0};
    logic [7:0]  prev_byte [2] = '{8'd0, 8'd0};
    logic [1:0]  prev_start = 2'b00;
    logic        rst_prev = 1'b0;
    int          checks = 0;
    int          errors = 0;

    command_executor #(.MEM_DEPTH(1024), .READ_LATENCY(1)) dut0 (
        .clock(clock), .reset(reset), .i_command(cmd_in), .i_address(addr_in),
        .i_data(data_in), .i_readwrite(rw_in), .i_error(err_in), .i_done(done_in),
        .o_mem_addr(mem_addr[0]), .o_mem_wdata(mem_wdata[0]), .o_mem_we(mem_we[0]),
        .i_mem_rdata(pipe1[0]), .o_tx_byte(tx_byte[0]), .o_tx_start(tx_start[0]),
        .i_tx_busy(tx_busy[0]), .o_busy(busy[0]), .o_dropped(dropped[0]));

    command_executor #(.MEM_DEPTH(1024), .READ_LATENCY(2)) dut1 (
        .clock(clock), .reset(reset), .i_command(cmd_in), .i_address(addr_in),
        .i_data(data_in), .i_readwrite(rw_in), .i_error(err_in), .i_done(done_in),
        .o_mem_addr(mem_addr[1]), .o_mem_wdata(mem_wdata[1]), .o_mem_we(mem_we[1]),
        .i_mem_rdata(pipe2[1]), .o_tx_byte(tx_byte[1]), .o_tx_start(tx_start[1]),
        .i_tx_busy(tx_busy[1]), .o_busy(busy[1]), .o_dropped(dropped[1]));

    always #5 clock = ~clock;

    assign tx_busy[0] = (tx_cnt[0] != 0);
    assign tx_busy[1] = (tx_cnt[1] != 0);

    // Memory read pipelines, transmitter busy models and event logging per instance.
    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_prev <= reset;
        for (int j = 0; j < 2; j++) begin
            pipe1[j] <= mem[mem_addr[j][9:0]];
            pipe2[j] <= pipe1[j];
            if (tx_start[j] === 1'b1) begin
                tx_cnt[j]                 <= tx_hold;
                tx_log[j][tx_n[j] & 63]   <= tx_byte[j];
                tx_rel[j][tx_n[j] & 63]   <= cyc - done_cyc;
                tx_n[j]                   <= tx_n[j] + 1;
            end else if (tx_cnt[j] != 0) begin
                tx_cnt[j] <= tx_cnt[j] - 1;
            end
            viol[j] <= viol[j]
                + (((tx_start[j] === 1'b1) && (tx_busy[j] || prev_start[j])) ? 1 : 0)
                + (((tx_start[j] === 1'b0) && rst_prev && (tx_byte[j] !== prev_byte[j])) ? 1 : 0);
            prev_start[j] <= tx_start[j];
            prev_byte[j]  <= tx_byte[j];
            if (mem_we[j] === 1'b1) begin
                we_n[j]        <= we_n[j] + 1;
                we_addr_log[j] <= mem_addr[j];
                we_data_log[j] <= mem_wdata[j];
                we_rel_log[j]  <= cyc - done_cyc;
            end
            if (dropped[j] === 1'b1) drop_n[j] <= drop_n[j] + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference status: decoder error wins, then range, then the operation.
    function automatic logic [7:0] exp_status(input logic [14:0] a, input logic rw,
                                              input logic [1:0] e);
        if (e != 2'd0) return {6'b101000, e};
        if (int'(a) >= 1024) return 8'hA8;
        return rw ? 8'hA4 : 8'hA0;
    endfunction

    task automatic pulse(input logic [14:0] a, input logic [31:0] d, input logic rw,
                         input logic [1:0] e);
        @(negedge clock);
        addr_in  = a;
        data_in  = d;
        rw_in    = rw;
        err_in   = e;
        cmd_in   = 8'($urandom_range(0, 255));
        done_in  = 1'b1;
        done_cyc = cyc;
        @(negedge clock);
        done_in = 1'b0;
    endtask

    task automatic run(input logic [14:0] a, input logic [31:0] d, input logic rw,
                       input logic [1:0] e, input int hold, input int drop_at);
        logic [7:0]  st;
        logic [7:0]  exp_b [5];
        logic [31:0] word;
        int          len;
        int          bt [2];
        int          bw [2];
        int          bd [2];
        int          bv [2];
        bit          sent;
        tx_hold = hold;
        st   = exp_status(a, rw, e);
        word = mem[a[9:0]];
        len  = (st == 8'hA4) ? 5 : 1;
        exp_b[0] = st;
        for (int i = 1; i < 5; i++) exp_b[i] = word[8*(i-1) +: 8];
        for (int j = 0; j < 2; j++) begin
            bt[j] = tx_n[j]; bw[j] = we_n[j]; bd[j] = drop_n[j]; bv[j] = viol[j];
        end
        pulse(a, d, rw, e);
        chk("busy_rise", 64'(busy), 64'(2'b11));
        sent = 1'b0;
        for (int k = 0; k < 3000 && busy != 2'b00; k++) begin
            if (drop_at > 0 && !sent && (tx_n[0] - bt[0]) >= drop_at) begin
                addr_in = 15'($urandom_range(0, 32767));
                rw_in   = 1'($urandom_range(0, 1));
                done_in = 1'b1;
                sent    = 1'b1;
                @(negedge clock);
                done_in = 1'b0;
            end else begin
                @(negedge clock);
            end
        end
        chk("idle_timeout", 64'(busy), 64'd0);
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("tx_count_i%0d_a%0h", j, a), 64'(tx_n[j] - bt[j]), 64'(len));
            for (int i = 0; i < len; i++)
                chk($sformatf("tx_byte%0d_i%0d_a%0h", i, j, a),
                    64'(tx_log[j][(bt[j] + i) & 63]), 64'(exp_b[i]));
            chk($sformatf("we_count_i%0d", j), 64'(we_n[j] - bw[j]), (st == 8'hA0) ? 64'd1 : 64'd0);
            if (st == 8'hA0) begin
                chk($sformatf("we_addr_i%0d", j), 64'(we_addr_log[j]), 64'(a));
                chk($sformatf("we_data_i%0d", j), 64'(we_data_log[j]), 64'(d));
                chk($sformatf("we_cycle_i%0d", j), 64'(we_rel_log[j]), 64'd2);
            end
            if (st == 8'hA0 || st == 8'hA4)
                chk($sformatf("first_start_cycle_i%0d", j), 64'(tx_rel[j][bt[j] & 63]),
                    (st == 8'hA0) ? 64'd3 : 64'(4 + j));
            chk($sformatf("protocol_i%0d", j), 64'(viol[j] - bv[j]), 64'd0);
            chk($sformatf("dropped_i%0d", j), 64'(drop_n[j] - bd[j]), (drop_at > 0) ? 64'd1 : 64'd0);
        end
        if (st == 8'hA0) mem[a[9:0]] = d;
    endtask

    initial begin
        int b0;
        int bs [2];
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        for (int j = 0; j < 2; j++)
            chk($sformatf("reset_state_i%0d", j),
                64'({mem_addr[j], mem_wdata[j], mem_we[j], tx_byte[j], tx_start[j], busy[j], dropped[j]}),
                64'd0);
        reset = 1'b1;
        @(negedge clock);

        run(15'h0012, 32'hDEADBEEF, 1'b0, 2'd0, 2, 0);
        mem[5] = 32'h11223344;
        run(15'h0005, 32'h0, 1'b1, 2'd0, 2, 0);
        run(15'h0007, 32'hCAFEF00D, 1'b1, 2'b10, 2, 0);
        run(15'h0003, 32'h12345678, 1'b0, 2'b01, 1, 0);
        run(15'h0400, 32'h0BADF00D, 1'b0, 2'd0, 2, 0);
        run(15'h0400, 32'h0, 1'b1, 2'd0, 2, 0);
        run(15'h7FFF, 32'h0, 1'b1, 2'b11, 0, 0);
        run(15'h03FF, 32'h0, 1'b1, 2'd0, 0, 0);
        run(15'h0005, 32'h0, 1'b1, 2'd0, 50, 0);
        run(15'h0012, 32'h0, 1'b1, 2'd0, 3, 0);
        run(15'h0009, 32'h0, 1'b1, 2'd0, 3, 2);

        for (int n = 0; n < 24; n++) begin
            logic [14:0] ra;
            logic [1:0]  re;
            ra = ($urandom_range(0, 7) == 0) ? 15'($urandom_range(1024, 32767))
                                             : 15'($urandom_range(0, 1023));
            re = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            run(ra, $urandom, 1'($urandom_range(0, 1)), re, $urandom_range(0, 6), 0);
        end

        // Reset in the middle of a read reply, after the second data byte.
        tx_hold = 3;
        b0 = tx_n[0];
        pulse(15'h0005, 32'h0, 1'b1, 2'd0);
        for (int k = 0; k < 500 && (tx_n[0] - b0) < 3; k++) @(negedge clock);
        chk("mid_reply_progress", 64'(tx_n[0] - b0), 64'd3);
        reset = 1'b0;
        @(negedge clock);
        for (int j = 0; j < 2; j++)
            chk($sformatf("mid_reset_outputs_i%0d", j),
                64'({mem_addr[j], mem_wdata[j], mem_we[j], tx_byte[j], tx_start[j], busy[j], dropped[j]}),
                64'd0);
        @(negedge clock);
        reset = 1'b1;
        bs[0] = tx_n[0];
        bs[1] = tx_n[1];
        repeat (40) @(negedge clock);
        for (int j = 0; j < 2; j++)
            chk($sformatf("no_start_after_reset_i%0d", j), 64'(tx_n[j] - bs[j]), 64'd0);
        chk("idle_after_reset", 64'(busy), 64'd0);
        run(15'h0005, 32'h0, 1'b1, 2'd0, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
